mul_sched: RTL and testbench
============================

MUL_SCHED -- requirements
Module: mul_sched

Interface
REQ-001 Parameter: RR_START, 0, requester holding first priority after reset (0 or 1).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 has an operand pair.
REQ-005 req0_ready  output  1  requester 0 operands accepted this cycle.
REQ-006 req0_a, req0_b  input  8 each  requester 0 operands.
REQ-007 req1_valid, req1_ready, req1_a, req1_b  same as REQ-004..006 for requester 1.
REQ-008 res_valid  output  1  product available.
REQ-009 res_ready  input  1  consumer accepts product.
REQ-010 res_p  output  16  product.
REQ-011 res_id  output  1  requester that owns res_p.
REQ-012 busy  output  1  high in any state except IDLE.

Function
REQ-013 Block SHALL compute an 8x8 product by four sequential passes through one shared 4x4 Wallace multiplier, accumulating into a 16-bit register.
REQ-014 FSM states SHALL be IDLE, P_LL, P_LH, P_HL, P_HH, DONE.
REQ-015 IDLE: if any req*_valid, the SHALL grant exactly one requester, pulse its ready for that cycle, latch a, b and id, clear the accumulator, and go to P_LL.
REQ-016 Arbitration SHALL be round-robin: when both requesters are valid, grant the one not granted last; the priority pointer SHALL update only on a grant.
REQ-017 P_LL, P_LH, P_HL, P_HH SHALL each take one cycle and add a[3:0]*b[3:0], a[3:0]*b[7:4]<<4, a[7:4]*b[3:0]<<4 and a[7:4]*b[7:4]<<8 respectively, in that order.
REQ-018 After P_HH the FSM SHALL enter DONE, assert res_valid, and hold res_p and res_id stable until res_valid&&res_ready.
REQ-019 The latency from the grant cycle to the first res_valid cycle SHALL be exactly 5 cycles.
REQ-020 On res_ready in DONE, the FSM SHALL go to IDLE; a new grant SHALL be possible in the following cycle, giving a minimum of 6 cycles per operation.
REQ-021 req*_ready SHALL be low in every state except IDLE; req*_valid outside IDLE SHALL be ignored and SHALL not be lost as long as the requester holds it.
REQ-022 Accumulation SHALL be modulo 2^16; the unsigned result cannot overflow.

Reset
REQ-023 Asserting rst SHALL force IDLE, accumulator 0, res_valid 0, res_p 0, res_id 0, req*_ready 0, busy 0, and set the priority pointer to RR_START.
REQ-024 Reset during any pass or DONE SHALL abort the operation; no res_valid SHALL appear for it.

Configuration
REQ-025 With MUL_SCHED_SIGNED_EN defined, operands SHALL be two's complement: at grant, store the magnitudes (-128 -> 128 as unsigned 8-bit) and sign = a[7]^b[7]; in DONE, res_p SHALL be negated when sign is set. Latency SHALL be unchanged.
REQ-026 Without MUL_SCHED_SIGNED_EN, operands and result SHALL be unsigned, and no sign logic SHALL be present.

Structure
REQ-027 A shared package SHALL hold the state encodings, the operand width (8) and the nibble width (4).
REQ-028 The existing 4x4 Wallace multiplier SHALL be instantiated exactly once as the only sub-module; nibble operands SHALL be selected by a mux from the state.

Verification
REQ-029 req0 a=13, b=11 -> res_p=0x008F, res_id=0, res_valid 5 cycles after the grant.
REQ-030 req1 a=0xFF, b=0xFF -> res_p=0xFE01, res_id=1.
REQ-031 Both requests valid after reset with RR_START=0 -> req0 served first, then req1; with both held, grants alternate 0,1,0.
REQ-032 res_ready held low for 3 cycles in DONE -> res_valid, res_p and res_id stay stable; the FSM returns to IDLE one cycle after res_ready rises.
REQ-033 rst pulsed in P_HL -> outputs take their reset values; no res_valid; the next request completes correctly.
REQ-034 SIGNED_EN: a=0xFD (-3), b=5 -> res_p=0xFFF1; a=0x80, b=0x80 -> 0x4000.

Source files
------------

// File: rtl/mul_sched_pkg.sv
// Shared constants for the mul_sched multiplier scheduler: widths and FSM state encodings.
package mul_sched_pkg;
    localparam int OP_W  = 8;
    localparam int NIB_W = 4;
    localparam int RES_W = 2 * OP_W;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_P_LL = 3'd1;
    localparam logic [2:0] S_P_LH = 3'd2;
    localparam logic [2:0] S_P_HL = 3'd3;
    localparam logic [2:0] S_P_HH = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
endpackage

// File: rtl/mul_sched_wallace.sv
// 4x4 unsigned Wallace-tree multiplier: partial products reduced by two carry-save
// layers, then a single carry-propagate add.
module mul_sched_wallace
    import mul_sched_pkg::*;
(
    input  logic [NIB_W-1:0]   i_a,
    input  logic [NIB_W-1:0]   i_b,
    output logic [2*NIB_W-1:0] o_p
);
    logic [2*NIB_W-1:0] w_pp [NIB_W];
    logic [2*NIB_W-1:0] w_s1;
    logic [2*NIB_W-1:0] w_c1;
    logic [2*NIB_W-1:0] w_s2;
    logic [2*NIB_W-1:0] w_c2;

    genvar gi;
    generate
        for (gi = 0; gi < NIB_W; gi++) begin : g_pp
            assign w_pp[gi] = {{NIB_W{1'b0}}, i_a & {NIB_W{i_b[gi]}}} << gi;
        end
    endgenerate

    // Product never exceeds 225, so carries dropped off the top bit are always zero.
    assign w_s1 = w_pp[0] ^ w_pp[1] ^ w_pp[2];
    assign w_c1 = ((w_pp[0] & w_pp[1]) | (w_pp[0] & w_pp[2]) | (w_pp[1] & w_pp[2])) << 1;
    assign w_s2 = w_s1 ^ w_c1 ^ w_pp[3];
    assign w_c2 = ((w_s1 & w_c1) | (w_s1 & w_pp[3]) | (w_c1 & w_pp[3])) << 1;
    assign o_p  = w_s2 + w_c2;
endmodule

// File: rtl/mul_sched.sv
// Two-requester round-robin 8x8 multiplier built from four passes through one 4x4 Wallace core.
// Define MUL_SCHED_SIGNED_EN for two's-complement operands and result.
module mul_sched
    import mul_sched_pkg::*;
#(
    parameter int RR_START = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OP_W-1:0]  req0_a,
    input  logic [OP_W-1:0]  req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OP_W-1:0]  req1_a,
    input  logic [OP_W-1:0]  req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [RES_W-1:0] res_p,
    output logic             res_id,
    output logic             busy
);
    logic [2:0]         r_state;
    logic [OP_W-1:0]    r_a;
    logic [OP_W-1:0]    r_b;
    logic               r_id;
    logic               r_prio;
    logic [RES_W-1:0]   r_acc;

    logic               w_idle;
    logic               w_grant_any;
    logic               w_grant_id;
    logic [OP_W-1:0]    w_sel_a;
    logic [OP_W-1:0]    w_sel_b;
    logic [OP_W-1:0]    w_op_a;
    logic [OP_W-1:0]    w_op_b;
    logic [NIB_W-1:0]   w_nib_a;
    logic [NIB_W-1:0]   w_nib_b;
    logic [2*NIB_W-1:0] w_nib_p;
    logic [RES_W-1:0]   w_term;

    assign w_idle      = (r_state == S_IDLE);
    assign w_grant_any = req0_valid | req1_valid;
    // Pointer only breaks ties; a lone requester always wins.
    assign w_grant_id  = (req0_valid & req1_valid) ? r_prio : req1_valid;

    assign req0_ready  = ~rst & w_idle & req0_valid & ~w_grant_id;
    assign req1_ready  = ~rst & w_idle & req1_valid &  w_grant_id;

    assign w_sel_a = w_grant_id ? req1_a : req0_a;
    assign w_sel_b = w_grant_id ? req1_b : req0_b;

`ifdef MUL_SCHED_SIGNED_EN
    logic r_sign;

    // -128 maps to 128, which still fits the unsigned 8-bit magnitude.
    assign w_op_a = w_sel_a[OP_W-1] ? ({OP_W{1'b0}} - w_sel_a) : w_sel_a;
    assign w_op_b = w_sel_b[OP_W-1] ? ({OP_W{1'b0}} - w_sel_b) : w_sel_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sign <= 1'b0;
        end else if (w_idle && w_grant_any) begin
            r_sign <= w_sel_a[OP_W-1] ^ w_sel_b[OP_W-1];
        end
    end

    assign res_p = (r_sign && (r_state == S_DONE)) ? ({RES_W{1'b0}} - r_acc) : r_acc;
`else
    assign w_op_a = w_sel_a;
    assign w_op_b = w_sel_b;
    assign res_p  = r_acc;
`endif

    always_comb begin
        w_nib_a = r_a[NIB_W-1:0];
        w_nib_b = r_b[NIB_W-1:0];
        w_term  = '0;
        case (r_state)
            S_P_LL: begin
                w_term = {{(RES_W-2*NIB_W){1'b0}}, w_nib_p};
            end
            S_P_LH: begin
                w_nib_b = r_b[OP_W-1:NIB_W];
                w_term  = {{(RES_W-2*NIB_W){1'b0}}, w_nib_p} << NIB_W;
            end
            S_P_HL: begin
                w_nib_a = r_a[OP_W-1:NIB_W];
                w_term  = {{(RES_W-2*NIB_W){1'b0}}, w_nib_p} << NIB_W;
            end
            S_P_HH: begin
                w_nib_a = r_a[OP_W-1:NIB_W];
                w_nib_b = r_b[OP_W-1:NIB_W];
                w_term  = {{(RES_W-2*NIB_W){1'b0}}, w_nib_p} << OP_W;
            end
            default: ;
        endcase
    end

    mul_sched_wallace u_wallace (
        .i_a (w_nib_a),
        .i_b (w_nib_b),
        .o_p (w_nib_p)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_id    <= 1'b0;
            r_prio  <= 1'(RR_START);
            r_acc   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_any) begin
                        r_state <= S_P_LL;
                        r_id    <= w_grant_id;
                        r_prio  <= ~w_grant_id;
                        r_a     <= w_op_a;
                        r_b     <= w_op_b;
                        r_acc   <= '0;
                    end
                end
                S_P_LL, S_P_LH, S_P_HL, S_P_HH: begin
                    r_acc   <= r_acc + w_term;
                    r_state <= r_state + 3'd1;
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign res_valid = (r_state == S_DONE);
    assign res_id    = r_id;
    assign busy      = ~w_idle;
endmodule

// File: tb/tb_mul_sched.sv
// Self-checking bench for mul_sched: vector table plus round-robin, stall and abort sequences.
module tb_mul_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic        res_valid, res_ready;
    logic [15:0] res_p;
    logic        res_id;
    logic        busy;

    typedef struct {
        logic        id;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        logic        id;
        logic [15:0] p;
    } exp_t;

    vec_t tv [8];
    exp_t sbq [$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   gcyc = 0;

    mul_sched #(.RR_START(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_p      (res_p),
        .res_id     (res_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
`ifdef MUL_SCHED_SIGNED_EN
        int sa;
        int sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        return 16'(sa * sb);
`else
        return 16'(int'(a) * int'(b));
`endif
    endfunction

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%04h, required 0x%04h", name, act, req);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    // Grant monitor: records the grant cycle and flags ready outside IDLE.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (req0_ready || req1_ready) gcyc = cyc;
            if ((req0_valid || req1_valid) && busy) begin
                checks++;
                if (req0_ready || req1_ready) begin
                    errors++;
                    $display("FAIL ready_outside_idle: got ready0=%b ready1=%b, required 0 0", req0_ready, req1_ready);
                end
            end
        end
    end

    task automatic issue(input logic id, input logic [7:0] a, input logic [7:0] b);
        int k;
        @(negedge clk);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end
        for (k = 0; k < 20; k++) begin
            #1;
            if (id ? req1_ready : req0_ready) break;
            @(negedge clk);
        end
        checks++;
        if (k == 20) begin
            errors++;
            $display("FAIL grant_timeout: got no ready for req%0d, required ready within 20 cycles", id);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic collect(input int stall);
        int   k;
        exp_t e;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (res_valid) break;
        end
        if (k == 20) begin
            checks++;
            errors++;
            $display("FAIL result_timeout: got no res_valid, required one within 20 cycles");
            return;
        end
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got res_p=0x%04h with empty scoreboard, required none", res_p);
            return;
        end
        e = sbq.pop_front();
        $display("result id=%0d p=0x%04h expected id=%0d p=0x%04h latency=%0d", res_id, res_p, e.id, e.p, cyc - gcyc);
        check16("latency", 16'(cyc - gcyc), 16'd5);
        check16("res_p", res_p, e.p);
        check1("res_id", res_id, e.id);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            #1;
            check1("hold_valid", res_valid, 1'b1);
            check16("hold_p", res_p, e.p);
            check1("hold_id", res_id, e.id);
        end
        res_ready = 1'b1;
        @(negedge clk);
        #1;
        res_ready = 1'b0;
        check1("valid_after_ack", res_valid, 1'b0);
        check1("idle_after_ack", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000 ns");
        $fatal(1);
    end

    initial begin
        logic [7:0] a0, b0, a1, b1;
        int seen;

        tv[0] = '{1'b0, 8'd13,  8'd11,  16'h008F};
`ifdef MUL_SCHED_SIGNED_EN
        tv[1] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
        tv[5] = '{1'b1, 8'hFD, 8'h05, 16'hFFF1};
        tv[6] = '{1'b0, 8'h7F, 8'h81, 16'hC0FF};
        tv[7] = '{1'b1, 8'hA5, 8'h0F, 16'hFAAB};
`else
        tv[1] = '{1'b1, 8'hFF, 8'hFF, 16'hFE01};
        tv[5] = '{1'b1, 8'hFD, 8'h05, 16'h04F1};
        tv[6] = '{1'b0, 8'h7F, 8'h81, 16'h3FFF};
        tv[7] = '{1'b1, 8'hA5, 8'h0F, 16'h09AB};
`endif
        tv[2] = '{1'b0, 8'h00, 8'h5A, 16'h0000};
        tv[3] = '{1'b1, 8'h80, 8'h80, 16'h4000};
        tv[4] = '{1'b0, 8'h12, 8'h34, 16'h03A8};

        rst = 1'b1;
        req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h22;
        req1_valid = 1'b0; req1_a = 8'h00; req1_b = 8'h00;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check1("rst_ready0", req0_ready, 1'b0);
        check1("rst_valid", res_valid, 1'b0);
        check16("rst_p", res_p, 16'h0000);
        check1("rst_id", res_id, 1'b0);
        check1("rst_busy", busy, 1'b0);
        req0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Both requesters held: grants must alternate 0,1,0.
        a0 = 8'h1D; b0 = 8'h2E; a1 = 8'hC4; b1 = 8'h09;
        @(negedge clk);
        req0_valid = 1'b1; req0_a = a0; req0_b = b0;
        req1_valid = 1'b1; req1_a = a1; req1_b = b1;
        sbq.push_back('{1'b0, model(a0, b0)});
        sbq.push_back('{1'b1, model(a1, b1)});
        sbq.push_back('{1'b0, model(a0, b0)});
        collect(0);
        collect(0);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        collect(0);

        for (int i = 0; i < 8; i++) begin
            sbq.push_back('{tv[i].id, tv[i].exp});
            issue(tv[i].id, tv[i].a, tv[i].b);
            collect(0);
        end

        // Consumer stalls three cycles in DONE.
        sbq.push_back('{1'b0, model(8'h3C, 8'hC3)});
        issue(1'b0, 8'h3C, 8'hC3);
        collect(3);

        // Abort during P_HL: issue returns in P_LL.
        sbq.push_back('{1'b1, model(8'h9A, 8'h77)});
        issue(1'b1, 8'h9A, 8'h77);
        @(negedge clk);
        @(negedge clk);
        #1;
        check1("pre_abort_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        check1("abort_valid", res_valid, 1'b0);
        check16("abort_p", res_p, 16'h0000);
        check1("abort_id", res_id, 1'b0);
        check1("abort_busy", busy, 1'b0);
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (res_valid) seen++;
        end
        check16("aborted_no_result", 16'(seen), 16'd0);
        sbq.push_back('{1'b0, model(8'hE7, 8'h3B)});
        issue(1'b0, 8'hE7, 8'h3B);
        collect(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
